// File: rtl/alert_pkg.sv
// Shared definitions for the alert sequencer: channel state encoding and
// width helpers used to size per-channel counters.
package alert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } alert_state_t;

    localparam int MAX_CH = 16;

    // Ceiling log2, never less than 1 so a 1-entry range still gets a real bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cycle_cnt_width(input int on_cycles, input int off_cycles);
        return clog2_min1(((on_cycles > off_cycles) ? on_cycles : off_cycles) + 1);
    endfunction

    function automatic int burst_cnt_width(input int num_bursts);
        return clog2_min1(num_bursts + 1);
    endfunction

endpackage

// File: rtl/alert_channel.sv
// One alert channel: IDLE/ON/GAP/DONE sequencer with cycle and burst counters.
// Outputs are decoded straight from the state register.
module alert_channel
    import alert_pkg::*;
#(
    parameter int ON_CYCLES  = 5,
    parameter int OFF_CYCLES = 0,
    parameter int NUM_BURSTS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic ack,
    input  logic cont_mode,
    output logic alert,
    output logic alert_off
);

    localparam int CW = cycle_cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam int BW = burst_cnt_width(NUM_BURSTS);
    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST  = CW'((OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0);
    localparam logic [BW-1:0] BURST_MAX = BW'(NUM_BURSTS);

    alert_state_t  state_reg;
    logic [CW-1:0] cyc_reg;
    logic [BW-1:0] burst_reg;
    logic          mode_reg;
    logic [BW-1:0] burst_next;

    // Saturates so continuous mode can run forever without wrapping.
    assign burst_next = (burst_reg == BURST_MAX) ? burst_reg : burst_reg + BW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cyc_reg   <= '0;
            burst_reg <= '0;
            mode_reg  <= 1'b0;
        end else if (!enable) begin
            state_reg <= ST_IDLE;
            cyc_reg   <= '0;
            burst_reg <= '0;
        end else if (ack && (state_reg == ST_ON || state_reg == ST_GAP)) begin
            state_reg <= ST_DONE;
            cyc_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_ON;
                    cyc_reg   <= '0;
                    burst_reg <= '0;
                    mode_reg  <= cont_mode;
                end
                ST_ON: begin
                    if (cyc_reg == ON_LAST) begin
                        cyc_reg   <= '0;
                        burst_reg <= burst_next;
                        if (!mode_reg && burst_next == BURST_MAX) begin
                            state_reg <= ST_DONE;
                        end else if (OFF_CYCLES > 0) begin
                            state_reg <= ST_GAP;
                        end else begin
                            state_reg <= ST_ON;
                        end
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cyc_reg == OFF_LAST) begin
                        state_reg <= ST_ON;
                        cyc_reg   <= '0;
                    end else begin
                        cyc_reg <= cyc_reg + CW'(1);
                    end
                end
                ST_DONE: state_reg <= ST_DONE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign alert     = (state_reg == ST_ON);
    assign alert_off = (state_reg == ST_DONE);

endmodule

// File: rtl/alert_controller.sv
// Multi-channel alert sequencer: NUM_CH independent channels plus a
// lowest-index-wins encoder for the shared buzzer/LED driver.
module alert_controller
    import alert_pkg::*;
#(
    parameter int NUM_CH     = 1,
    parameter int ON_CYCLES  = 5,
    parameter int OFF_CYCLES = 0,
    parameter int NUM_BURSTS = 1,
    localparam int ID_W      = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] ack,
    input  logic              cont_mode,
    output logic [NUM_CH-1:0] alert,
    output logic [NUM_CH-1:0] alert_off,
    output logic              alert_any,
    output logic [ID_W-1:0]   active_id,
    output logic              active_valid
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            alert_channel #(
                .ON_CYCLES (ON_CYCLES),
                .OFF_CYCLES(OFF_CYCLES),
                .NUM_BURSTS(NUM_BURSTS)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .enable   (enable[gi]),
                .ack      (ack[gi]),
                .cont_mode(cont_mode),
                .alert    (alert[gi]),
                .alert_off(alert_off[gi])
            );
        end
    endgenerate

    logic [ID_W-1:0] active_id_next;

    // Scan high to low so the lowest asserted index is the last one written.
    always_comb begin
        active_id_next = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (alert[i]) begin
                active_id_next = ID_W'(i);
            end
        end
    end

    assign active_id    = active_id_next;
    assign alert_any    = |alert;
    assign active_valid = alert_any;

endmodule

// File: tb/tb_alert_controller.sv
// Bench for alert_controller: a default single-channel instance and a 4-channel
// ON=2/OFF=3/BURSTS=3 instance, both compared against a time-based reference.
module tb_alert_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en0, ack0;
    logic [3:0] en1, ack1;
    logic       cont;

    logic       alert0, off0, any0, valid0;
    logic [0:0] id0;
    logic [3:0] alert1, off1;
    logic       any1, valid1;
    logic [1:0] id1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alert_controller #(.NUM_CH(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .ack(ack0), .cont_mode(cont),
        .alert(alert0), .alert_off(off0), .alert_any(any0),
        .active_id(id0), .active_valid(valid0)
    );

    alert_controller #(.NUM_CH(4), .ON_CYCLES(2), .OFF_CYCLES(3), .NUM_BURSTS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .ack(ack1), .cont_mode(cont),
        .alert(alert1), .alert_off(off1), .alert_any(any1),
        .active_id(id1), .active_valid(valid1)
    );

    // Reference: index 0 is dut0, indices 1..4 are dut1 channels 0..3.
    // A sequence is described by elapsed cycles t since start; the alert
    // pattern is periodic in (ON+OFF) and one-shot ends after the last burst.
    int m_on[5], m_off[5], m_bursts[5], m_t[5];
    bit m_started[5], m_acked[5], m_mode[5];

    function automatic bit m_done(input int c);
        return m_acked[c] ||
               (!m_mode[c] && m_t[c] >= m_bursts[c] * m_on[c] + (m_bursts[c] - 1) * m_off[c]);
    endfunction

    function automatic bit m_alert(input int c);
        return m_started[c] && !m_done(c) && ((m_t[c] % (m_on[c] + m_off[c])) < m_on[c]);
    endfunction

    function automatic bit m_in_gap(input int c);
        return m_started[c] && !m_done(c) && ((m_t[c] % (m_on[c] + m_off[c])) >= m_on[c]);
    endfunction

    function automatic logic [3:0] exp_alert1();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_alert(i + 1);
        return v;
    endfunction

    function automatic logic [3:0] exp_off1();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_started[i + 1] && m_done(i + 1);
        return v;
    endfunction

    function automatic logic [1:0] exp_id1();
        logic [3:0] v;
        logic [1:0] id;
        v  = exp_alert1();
        id = 2'd0;
        for (int i = 3; i >= 0; i--) if (v[i]) id = 2'(i);
        return id;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 5; c++) begin
            m_started[c] = 1'b0;
            m_acked[c]   = 1'b0;
            m_t[c]       = 0;
        end
    endfunction

    // Advance one clock, update the reference with the inputs seen at the edge,
    // and return 1 time unit later for sampling.
    task automatic tick();
        logic e, a;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                e = en0; a = ack0;
            end else begin
                e = en1[c - 1]; a = ack1[c - 1];
            end
            if (!rst_n || !e) begin
                m_started[c] = 1'b0; m_acked[c] = 1'b0; m_t[c] = 0;
            end else if (!m_started[c]) begin
                m_started[c] = 1'b1; m_acked[c] = 1'b0; m_t[c] = 0; m_mode[c] = cont;
            end else if (!m_done(c)) begin
                if (a) m_acked[c] = 1'b1;
                else   m_t[c] = m_t[c] + 1;
            end
        end
        #1;
    endtask

    task automatic idle_all();
        en0 = 1'b0; ack0 = 1'b0; en1 = 4'd0; ack1 = 4'd0; cont = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en0 = 1'b0; ack0 = 1'b0; en1 = 4'd0; ack1 = 4'd0; cont = 1'b0;
        model_clear();
        #2;
        tick();
        checks++;
        if ({alert0, off0, any0, valid0, id0} !== 5'd0) begin
            errors++; $display("FAIL reset dut0 outputs act=%b req=00000", {alert0, off0, any0, valid0, id0});
        end
        checks++;
        if ({alert1, off1, any1, valid1, id1} !== 12'd0) begin
            errors++; $display("FAIL reset dut1 outputs act=%b req=0", {alert1, off1, any1, valid1, id1});
        end
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_default();
        int high_cnt;
        high_cnt = 0;
        en0 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            high_cnt += int'(alert0);
            checks++;
            if (alert0 !== m_alert(0) || off0 !== (m_started[0] && m_done(0))) begin
                errors++; $display("FAIL default cyc%0d alert/off act=%b%b req=%b%b",
                                   i, alert0, off0, m_alert(0), m_started[0] && m_done(0));
            end
            checks++;
            if (any0 !== alert0 || valid0 !== alert0 || id0 !== 1'b0) begin
                errors++; $display("FAIL default cyc%0d any/valid/id act=%b%b%b req=%b%b0",
                                   i, any0, valid0, id0, alert0, alert0);
            end
        end
        checks++;
        if (high_cnt != 5 || off0 !== 1'b1) begin
            errors++; $display("FAIL default high_cycles act=%0d off=%b req=5 off=1", high_cnt, off0);
        end
        en0 = 1'b0;
        tick();
        checks++;
        if (alert0 !== 1'b0 || off0 !== 1'b0) begin
            errors++; $display("FAIL default drop act=%b%b req=00", alert0, off0);
        end
        $display("test_default done");
    endtask

    task automatic test_bursts();
        logic [13:0] pat;
        pat = 14'b11000110001100;
        en1[0] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++;
            if (alert1 !== exp_alert1() || off1 !== exp_off1()) begin
                errors++; $display("FAIL bursts cyc%0d alert/off act=%b/%b req=%b/%b",
                                   i, alert1, off1, exp_alert1(), exp_off1());
            end
            if (i < 14) begin
                checks++;
                if (alert1[0] !== pat[13 - i]) begin
                    errors++; $display("FAIL bursts pattern cyc%0d act=%b req=%b", i, alert1[0], pat[13 - i]);
                end
            end
        end
        checks++;
        if (off1[0] !== 1'b1) begin
            errors++; $display("FAIL bursts done act=%b req=1", off1[0]);
        end
        idle_all();
        $display("test_bursts done");
    endtask

    task automatic test_continuous();
        bit found;
        found = 1'b0;
        cont = 1'b1; en1[2] = 1'b1; en0 = 1'b1;
        tick();
        cont = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (alert1 !== exp_alert1() || off1 !== exp_off1() || alert0 !== m_alert(0) || off0 !== (m_started[0] && m_done(0))) begin
                errors++; $display("FAIL continuous cyc%0d act=%b/%b/%b%b req=%b/%b/%b%b", i, alert1, off1, alert0, off0,
                                   exp_alert1(), exp_off1(), m_alert(0), m_started[0] && m_done(0));
            end
        end
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_in_gap(3)) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL continuous gap_search act=none req=gap_within_10");
        end
        ack1[2] = 1'b1; ack0 = 1'b1;
        tick();
        ack1[2] = 1'b0; ack0 = 1'b0;
        checks++;
        if (off1[2] !== 1'b1 || alert1[2] !== 1'b0 || off0 !== 1'b1 || alert0 !== 1'b0) begin
            errors++; $display("FAIL continuous ack act=%b%b%b%b req=1010", off1[2], alert1[2], off0, alert0);
        end
        tick();
        checks++;
        if (off1 !== exp_off1() || off1[2] !== 1'b1) begin
            errors++; $display("FAIL continuous hold act=%b req=%b", off1, exp_off1());
        end
        idle_all();
        $display("test_continuous done");
    endtask

    task automatic test_priority();
        cont = 1'b1; en1[3] = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (i == 1) begin
                cont = 1'b0; en1[1] = 1'b1;
            end
            checks++;
            if (id1 !== exp_id1() || valid1 !== (|exp_alert1()) || any1 !== (|exp_alert1()) || alert1 !== exp_alert1()) begin
                errors++; $display("FAIL priority cyc%0d id/valid/any/alert act=%0d/%b/%b/%b req=%0d/%b/%b/%b",
                                   i, id1, valid1, any1, alert1, exp_id1(), |exp_alert1(), |exp_alert1(), exp_alert1());
            end
        end
        checks++;
        if (off1[1] !== 1'b1 || off1[3] !== 1'b0) begin
            errors++; $display("FAIL priority final ch1_off/ch3_off act=%b%b req=10", off1[1], off1[3]);
        end
        idle_all();
        $display("test_priority done");
    endtask

    task automatic test_reenable();
        int high_cnt;
        high_cnt = 0;
        en0 = 1'b1;
        repeat ($urandom_range(2, 4)) tick();
        en0 = 1'b0;
        tick();
        checks++;
        if (alert0 !== 1'b0) begin
            errors++; $display("FAIL reenable drop act=%b req=0", alert0);
        end
        en0 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            high_cnt += int'(alert0);
            checks++;
            if (alert0 !== m_alert(0) || off0 !== (m_started[0] && m_done(0))) begin
                errors++; $display("FAIL reenable cyc%0d act=%b%b req=%b%b", i, alert0, off0, m_alert(0), m_started[0] && m_done(0));
            end
        end
        checks++;
        if (high_cnt != 5) begin
            errors++; $display("FAIL reenable high_cycles act=%0d req=5", high_cnt);
        end
        idle_all();
        $display("test_reenable done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) en0 = ~en0;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) en1[b] = ~en1[b];
            ack0 = ($urandom_range(0, 15) == 0);
            for (int b = 0; b < 4; b++) ack1[b] = ($urandom_range(0, 15) == 0);
            cont = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (alert0 !== m_alert(0) || off0 !== (m_started[0] && m_done(0)) || any0 !== m_alert(0)) begin
                errors++; $display("FAIL random cyc%0d dut0 act=%b%b%b req=%b%b%b", i, alert0, off0, any0,
                                   m_alert(0), m_started[0] && m_done(0), m_alert(0));
            end
            checks++;
            if (alert1 !== exp_alert1() || off1 !== exp_off1() || id1 !== exp_id1() || valid1 !== (|exp_alert1())) begin
                errors++; $display("FAIL random cyc%0d dut1 alert/off/id/valid act=%b/%b/%0d/%b req=%b/%b/%0d/%b", i,
                                   alert1, off1, id1, valid1, exp_alert1(), exp_off1(), exp_id1(), |exp_alert1());
            end
        end
        idle_all();
        $display("test_random done");
    endtask

    task automatic test_async_reset();
        en0 = 1'b1; en1 = 4'b0101;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({alert0, off0, any0, valid0} !== 4'd0 || {alert1, off1, any1, valid1, id1} !== 12'd0) begin
            errors++; $display("FAIL async_reset immediate act=%b/%b req=0/0",
                               {alert0, off0, any0, valid0}, {alert1, off1, any1, valid1, id1});
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (alert0 !== 1'b1 || alert1 !== exp_alert1() || alert1 !== 4'b0101) begin
            errors++; $display("FAIL async_reset release act=%b/%b req=1/0101", alert0, alert1);
        end
        idle_all();
        $display("test_async_reset done");
    endtask

    initial begin
        for (int c = 0; c < 5; c++) begin
            m_on[c]     = (c == 0) ? 5 : 2;
            m_off[c]    = (c == 0) ? 0 : 3;
            m_bursts[c] = (c == 0) ? 1 : 3;
            m_mode[c]   = 1'b0;
        end
        test_reset();
        test_default();
        test_bursts();
        test_continuous();
        test_priority();
        test_reenable();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
